// File: rtl/sevenseg_capture_if.sv
// Bus bundle for the seven-segment capture monitor: the observed scan lines
// (seg/an) travel toward the capture block, the reconstructed digits come back.
interface sevenseg_capture_if;
   logic [6:0]  seg;          // {g,f,e,d,c,b,a}, active-low
   logic [3:0]  an;           // anode enables, active-low
   logic [15:0] digits;       // digit i in digits[4*i+3:4*i]
   logic [3:0]  digit_valid;
   logic [3:0]  digit_err;
   logic        upd;
   logic [1:0]  upd_idx;

   // Side that drives the display scan and watches the captured result
   modport master (
      output seg,
      output an,
      input  digits,
      input  digit_valid,
      input  digit_err,
      input  upd,
      input  upd_idx
   );

   // Capture block: observes the scan, reports the decoded digits
   modport slave (
      input  seg,
      input  an,
      output digits,
      output digit_valid,
      output digit_err,
      output upd,
      output upd_idx
   );
endinterface

// File: rtl/sevenseg_capture.sv
// Seven-segment scan monitor: samples a multiplexed 4-digit active-low bus,
// waits for each {an,seg} pattern to hold steady, decodes the glyph into a hex
// value and tracks per-digit validity (legal glyph, refreshed recently).
module sevenseg_capture #(
   parameter int STABLE_CYCLES = 4,
   parameter int TIMEOUT       = 1048576
) (
   input logic               clk,
   input logic               rst,
   sevenseg_capture_if.slave bus
);

   localparam int SW = $clog2(STABLE_CYCLES + 1);
   localparam int AW = $clog2(TIMEOUT + 1);

   localparam logic [SW-1:0] STABLE_MAX  = SW'(STABLE_CYCLES);
   localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
   localparam logic [AW-1:0] AGE_MAX     = AW'(TIMEOUT);
   localparam logic [AW-1:0] AGE_LAST    = AW'(TIMEOUT - 1);

   logic [3:0]    r_an;
   logic [6:0]    r_seg;
   logic [SW-1:0] r_stable;
   logic          r_upd;
   logic [1:0]    r_upd_idx;

   logic          w_one_hot;
   logic [1:0]    w_idx;
   logic          w_same;
   logic          w_commit;
   logic [3:0]    w_sel;
   logic          w_glyph_ok;
   logic [3:0]    w_val;

   // Classify the anode pattern: exactly one low line selects a digit
   always_comb begin
      w_one_hot = 1'b0;
      w_idx     = 2'd0;
      case (bus.an)
         4'b1110: begin w_one_hot = 1'b1; w_idx = 2'd0; end
         4'b1101: begin w_one_hot = 1'b1; w_idx = 2'd1; end
         4'b1011: begin w_one_hot = 1'b1; w_idx = 2'd2; end
         4'b0111: begin w_one_hot = 1'b1; w_idx = 2'd3; end
         default: begin w_one_hot = 1'b0; w_idx = 2'd0; end
      endcase
   end

   // Glyph lookup; anything outside the sixteen hex shapes is illegal
   always_comb begin
      w_glyph_ok = 1'b1;
      w_val      = 4'h0;
      case (bus.seg)
         7'h40: w_val = 4'h0;
         7'h79: w_val = 4'h1;
         7'h24: w_val = 4'h2;
         7'h30: w_val = 4'h3;
         7'h19: w_val = 4'h4;
         7'h12: w_val = 4'h5;
         7'h02: w_val = 4'h6;
         7'h78: w_val = 4'h7;
         7'h00: w_val = 4'h8;
         7'h18: w_val = 4'h9;
         7'h08: w_val = 4'hA;
         7'h03: w_val = 4'hB;
         7'h46: w_val = 4'hC;
         7'h21: w_val = 4'hD;
         7'h06: w_val = 4'hE;
         7'h0E: w_val = 4'hF;
         default: begin w_glyph_ok = 1'b0; w_val = 4'h0; end
      endcase
   end

   // A commit fires on the edge where the stable run reaches its full length;
   // the counter then parks at its maximum so a steady window commits once.
   always_comb begin
      w_same   = ({bus.an, bus.seg} == {r_an, r_seg});
      w_commit = w_one_hot && w_same && (r_stable == STABLE_LAST);
      w_sel    = w_commit ? ~bus.an : 4'b0000;
   end

   // Sample the bus and measure how long the current legal pattern has held
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_an     <= 4'hF;
         r_seg    <= 7'h7F;
         r_stable <= '0;
      end else begin
         r_an  <= bus.an;
         r_seg <= bus.seg;
         if (w_one_hot && w_same) begin
            if (r_stable != STABLE_MAX)
               r_stable <= r_stable + 1'b1;
         end else begin
            r_stable <= '0;
         end
      end
   end

   // One-cycle update strobe with the index of the digit just committed
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_upd     <= 1'b0;
         r_upd_idx <= 2'd0;
      end else begin
         r_upd <= w_commit;
         if (w_commit)
            r_upd_idx <= w_idx;
      end
   end

   assign bus.upd     = r_upd;
   assign bus.upd_idx = r_upd_idx;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_digit
         logic [3:0]    r_digit;
         logic          r_valid;
         logic          r_err;
         logic [AW-1:0] r_age;

         // Per-digit capture and aging; a commit takes priority over expiry
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_digit <= 4'h0;
               r_valid <= 1'b0;
               r_err   <= 1'b0;
               r_age   <= '0;
            end else if (w_sel[gi]) begin
               r_age <= '0;
               if (w_glyph_ok) begin
                  r_digit <= w_val;
                  r_valid <= 1'b1;
                  r_err   <= 1'b0;
               end else begin
                  r_valid <= 1'b0;
                  r_err   <= 1'b1;
               end
            end else if (r_age != AGE_MAX) begin
               r_age <= r_age + 1'b1;
               if (r_age == AGE_LAST)
                  r_valid <= 1'b0;
            end
         end

         assign bus.digits[4*gi +: 4] = r_digit;
         assign bus.digit_valid[gi]   = r_valid;
         assign bus.digit_err[gi]     = r_err;
      end
   endgenerate

endmodule
